sub_bytes_mc: RTL and testbench

- Parametrised, multi-cycle SubBytes engine for the AES-128 datapath.
- Substitutes all 16 bytes of a 128-bit state through LANES S-box instances, processing LANES bytes per clock. This trades area against latency.
- Optional inverse S-box mode, selected per transaction, serves the decryptor's InvSubBytes.
- Uses a valid/ready handshake on both sides so the round controller can stall it.

---
 rtl/sub_bytes_mc.sv | 144 ++++++++++++++
 tb/tb_sub_bytes_mc.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_mc.sv
// Multi-cycle AES SubBytes / InvSubBytes engine, LANES bytes substituted per clock.
// Latency: 16/LANES cycles from accept to out_valid; one state per 16/LANES+2 cycles.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE (no bypass).
module sub_bytes_mc #(
    parameter int LANES      = 4,
    parameter bit INVERSE_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int GROUPS = 16 / LANES;
    localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(GROUPS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("sub_bytes_mc: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    localparam logic [0:255][7:0] SBOX_FWD = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [0:255][7:0] SBOX_INV = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    // With INVERSE_EN=0 the inverse branch folds away and its table is never referenced.
    function automatic logic [7:0] subst(input logic [7:0] b, input logic inv);
        return (INVERSE_EN && inv) ? SBOX_INV[b] : SBOX_FWD[b];
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q;
    logic [127:0]    work_q, work_d;
    logic [127:0]    out_state_q;
    logic            mode_q;
    logic            accept;
    logic            last_grp;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_grp  = (cnt_q == LAST);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_state = out_state_q;

    // Replace the current group of LANES bytes in place, low byte first.
    always_comb begin
        work_d = work_q;
        for (int l = 0; l < LANES; l++) begin
            work_d[(int'(cnt_q) * LANES + l) * 8 +: 8] =
                subst(work_q[(int'(cnt_q) * LANES + l) * 8 +: 8], mode_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = SUB;
            SUB:     if (last_grp) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            work_q      <= '0;
            mode_q      <= 1'b0;
            out_state_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        work_q <= in_state;
                        mode_q <= INVERSE_EN ? in_inv : 1'b0;
                        cnt_q  <= '0;
                    end
                end
                SUB: begin
                    work_q <= work_d;
                    if (last_grp) begin
                        cnt_q       <= '0;
                        out_state_q <= work_d;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_mc.sv
// Directed bench for sub_bytes_mc across LANES=4/1/16/2 and a forward-only build.
// Expected states are the FIPS-197 S-box images of the stimulus, computed by hand.
module tb_sub_bytes_mc;

    localparam int N = 5;  // 0:L4 inv, 1:L1, 2:L16, 3:L2, 4:L4 fwd-only

    localparam logic [127:0] VEC_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] VEC_SB  = 128'h638293c31bfc33f5c4eeacea4bc12816;
    localparam logic [127:0] ALL_63  = {16{8'h63}};

    logic         clk;
    logic         rst;
    logic         in_valid  [N];
    logic         in_ready  [N];
    logic [127:0] in_state  [N];
    logic         in_inv    [N];
    logic         out_valid [N];
    logic         out_ready [N];
    logic [127:0] out_state [N];
    logic         busy      [N];

    int vectors = 0;
    int errors  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    sub_bytes_mc #(.LANES(4), .INVERSE_EN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_state(in_state[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_state(out_state[0]), .busy(busy[0]));
    sub_bytes_mc #(.LANES(1), .INVERSE_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_state(in_state[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_state(out_state[1]), .busy(busy[1]));
    sub_bytes_mc #(.LANES(16), .INVERSE_EN(1'b1)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_state(in_state[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_state(out_state[2]), .busy(busy[2]));
    sub_bytes_mc #(.LANES(2), .INVERSE_EN(1'b1)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_state(in_state[3]), .in_inv(in_inv[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .out_state(out_state[3]), .busy(busy[3]));
    sub_bytes_mc #(.LANES(4), .INVERSE_EN(1'b0)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid[4]), .in_ready(in_ready[4]),
        .in_state(in_state[4]), .in_inv(in_inv[4]), .out_valid(out_valid[4]),
        .out_ready(out_ready[4]), .out_state(out_state[4]), .busy(busy[4]));

    // Present a state at the negedge, accept on the next posedge, then flip in_inv.
    task automatic start(input int k, input logic [127:0] st, input logic inv, input string name);
        @(negedge clk);
        in_valid[k] = 1'b1;
        in_state[k] = st;
        in_inv[k]   = inv;
        vectors++;
        if (in_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, in_ready[k]);
        end
        @(posedge clk);
        #1;
        in_valid[k] = 1'b0;
        in_state[k] = ~st;
        in_inv[k]   = ~inv;
    endtask

    // Count edges until out_valid, then check latency, result and busy.
    task automatic wait_done(input int k, input int exp_lat, input logic [127:0] exp_st,
                             input string name);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid[k] === 1'b1) got = 1'b1;
        end
        vectors++;
        if (!got || lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d (seen=%0d) want %0d", name, lat, got, exp_lat);
        end
        vectors++;
        if (out_state[k] !== exp_st) begin
            errors++;
            $display("FAIL %s out_state: got %h want %h", name, out_state[k], exp_st);
        end
        vectors++;
        if (busy[k] !== 1'b1 || in_ready[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s done_flags: busy=%b in_ready=%b want 1/0", name, busy[k], in_ready[k]);
        end
    endtask

    // With out_ready high, the DONE edge returns to IDLE.
    task automatic check_release(input int k, input string name);
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || busy[k] !== 1'b0) begin
            errors++;
            $display("FAIL %s release: out_valid=%b in_ready=%b busy=%b want 0/1/0",
                     name, out_valid[k], in_ready[k], busy[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            in_valid[k]  = 1'b0;
            in_state[k]  = '0;
            in_inv[k]    = 1'b0;
            out_ready[k] = 1'b1;
        end
        #1;
        for (int k = 0; k < N; k++) begin
            vectors++;
            if (in_ready[k] !== 1'b0 || out_valid[k] !== 1'b0 || busy[k] !== 1'b0
                || out_state[k] !== 128'h0) begin
                errors++;
                $display("FAIL reset dut%0d: in_ready=%b out_valid=%b busy=%b out_state=%h want 0/0/0/0",
                         k, in_ready[k], out_valid[k], busy[k], out_state[k]);
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready: got %b want 1", in_ready[0]);
        end
    endtask

    task automatic test_forward();
        start(0, VEC_PT, 1'b0, "fwd_l4");
        wait_done(0, 4, VEC_SB, "fwd_l4");
        check_release(0, "fwd_l4");
    endtask

    task automatic test_inverse();
        start(0, VEC_SB, 1'b1, "inv_l4");
        wait_done(0, 4, VEC_PT, "inv_l4");
        check_release(0, "inv_l4");
        start(0, ALL_63, 1'b1, "inv_63");
        wait_done(0, 4, 128'h0, "inv_63");
        check_release(0, "inv_63");
    endtask

    task automatic test_backpressure();
        out_ready[1] = 1'b0;
        start(1, 128'h0, 1'b0, "bp_l1");
        wait_done(1, 16, ALL_63, "bp_l1");
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid[1] !== 1'b1 || out_state[1] !== ALL_63 || in_ready[1] !== 1'b0
                || busy[1] !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold cyc%0d: out_valid=%b in_ready=%b busy=%b out_state=%h",
                         c, out_valid[1], in_ready[1], busy[1], out_state[1]);
            end
        end
        @(negedge clk);
        out_ready[1] = 1'b1;
        check_release(1, "bp_l1");
    endtask

    task automatic test_lanes();
        start(2, VEC_PT, 1'b0, "fwd_l16");
        wait_done(2, 1, VEC_SB, "fwd_l16");
        check_release(2, "fwd_l16");
        start(3, VEC_PT, 1'b0, "fwd_l2");
        wait_done(3, 8, VEC_SB, "fwd_l2");
        check_release(3, "fwd_l2");
    endtask

    task automatic test_reset_midop();
        start(0, VEC_PT, 1'b0, "midop");
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (out_valid[0] !== 1'b0 || out_state[0] !== 128'h0 || busy[0] !== 1'b0
            || in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL midop_reset: out_valid=%b busy=%b in_ready=%b out_state=%h want 0/0/0/0",
                     out_valid[0], busy[0], in_ready[0], out_state[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            errors++;
            $display("FAIL midop_after: in_ready=%b out_valid=%b want 1/0", in_ready[0], out_valid[0]);
        end
        start(0, VEC_SB, 1'b1, "midop_new");
        wait_done(0, 4, VEC_PT, "midop_new");
        check_release(0, "midop_new");
    endtask

    task automatic test_fwd_only();
        start(4, 128'h0, 1'b1, "fwdonly");
        @(negedge clk);
        in_valid[4] = 1'b1;
        in_state[4] = {16{8'hff}};
        @(posedge clk);
        #1;
        in_valid[4] = 1'b0;
        wait_done(4, 3, ALL_63, "fwdonly");
        check_release(4, "fwdonly");
        repeat (3) begin
            @(posedge clk);
            #1;
            vectors++;
            if (busy[4] !== 1'b0 || out_valid[4] !== 1'b0) begin
                errors++;
                $display("FAIL fwdonly_no_ghost: busy=%b out_valid=%b want 0/0", busy[4], out_valid[4]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_lanes();
        test_reset_midop();
        test_fwd_only();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
